// File: rtl/seq_uart_dump.sv
// Snapshots the STEPS x 4-bit step pattern on start and streams it as one ASCII line
// ("S:" + hex digits + CR LF) over the txdata/txclk/txready UART port. Optional: SEQ_DUMP_SEP_EN.
`timescale 1ns/1ps
module seq_uart_dump #(
  parameter int STEPS     = 8,
  parameter int BUSY_WAIT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [4*STEPS-1:0]   seq_flat,
  input  logic                 txready,
  output logic [7:0]           txdata,
  output logic                 txclk,
  output logic                 busy,
  output logic                 done
);
  localparam int IW = $clog2(2*STEPS+4);
  localparam int WW = $clog2(BUSY_WAIT+1);
`ifdef SEQ_DUMP_SEP_EN
  localparam int LEN = 2*STEPS+3;
`else
  localparam int LEN = STEPS+4;
`endif
  localparam logic [IW-1:0] LAST    = IW'(LEN-1);
  localparam logic [IW-1:0] LAST_CR = IW'(LEN-2);
  localparam logic [WW-1:0] WAIT_MAX = WW'(BUSY_WAIT-1);

  typedef enum logic [2:0] {IDLE, SEND, WAIT_LOW, WAIT_HIGH, FIN} state_t;

  state_t             state, state_d;
  logic [IW-1:0]      idx, idx_d, d;
  logic [WW-1:0]      wcnt, wcnt_d;
  logic [4*STEPS-1:0] snap, snap_d;
  logic [7:0]         txdata_d, cur_byte;
  logic [3:0]         nib;
  logic               txclk_d, busy_d, done_d;

  function automatic logic [7:0] hex_digit(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  // Byte at the current line position, derived from the snapshot.
  always_comb begin
    d        = idx - IW'(2);
`ifdef SEQ_DUMP_SEP_EN
    nib      = 4'(snap >> {d[IW-1:1], 2'b00});
`else
    nib      = 4'(snap >> {d, 2'b00});
`endif
    cur_byte = hex_digit(nib);
    if (idx == '0)              cur_byte = 8'h53;
    else if (idx == IW'(1))     cur_byte = 8'h3A;
    else if (idx == LAST_CR)    cur_byte = 8'h0D;
    else if (idx == LAST)       cur_byte = 8'h0A;
`ifdef SEQ_DUMP_SEP_EN
    else if (d[0])              cur_byte = 8'h20;
`endif
  end

  always_comb begin
    state_d  = state;
    idx_d    = idx;
    snap_d   = snap;
    wcnt_d   = wcnt;
    txdata_d = txdata;
    txclk_d  = 1'b0;
    busy_d   = busy;
    done_d   = 1'b0;
    case (state)
      IDLE: if (start) begin
        snap_d  = seq_flat;
        idx_d   = '0;
        busy_d  = 1'b1;
        state_d = SEND;
      end
      SEND: if (txready) begin
        txdata_d = cur_byte;
        txclk_d  = 1'b1;
        wcnt_d   = '0;
        state_d  = WAIT_LOW;
      end
      // A UART that never drops ready must not hang the line: time out after BUSY_WAIT.
      WAIT_LOW: begin
        if (!txready || wcnt >= WAIT_MAX) state_d = WAIT_HIGH;
        else                              wcnt_d  = wcnt + WW'(1);
      end
      WAIT_HIGH: if (txready) begin
        if (idx == LAST) state_d = FIN;
        else begin
          idx_d   = idx + IW'(1);
          state_d = SEND;
        end
      end
      FIN: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      idx    <= '0;
      snap   <= '0;
      wcnt   <= '0;
      txdata <= 8'h00;
      txclk  <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_d;
      idx    <= idx_d;
      snap   <= snap_d;
      wcnt   <= wcnt_d;
      txdata <= txdata_d;
      txclk  <= txclk_d;
      busy   <= busy_d;
      done   <= done_d;
    end
  end
endmodule

// File: tb/tb_seq_uart_dump.sv
// Bench for seq_uart_dump: line model + per-cycle compare process, UART ready model, directed tests.
`timescale 1ns/1ps
module tb_seq_uart_dump;
  localparam int STEPS = 8;
  localparam int BUSY_WAIT = 16;

  logic clk = 0, rst = 1, start = 0, txready = 1;
  logic [4*STEPS-1:0] seq_flat = '0;
  logic [7:0] txdata;
  logic txclk, busy, done;

  seq_uart_dump #(.STEPS(STEPS), .BUSY_WAIT(BUSY_WAIT)) dut (
    .clk(clk), .rst(rst), .start(start), .seq_flat(seq_flat), .txready(txready),
    .txdata(txdata), .txclk(txclk), .busy(busy), .done(done));

  always #5 clk = ~clk;

  int nvec = 0, nfail = 0;
  logic [7:0] exp_line [$];
  logic [7:0] rx_all [$];
  logic [7:0] lit [$];
  int ntx_total = 0, dcount = 0, cyc = 0, base_tx = 0, stall_k = -1;
  bit never_drop = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: the line is built straight from the text format, not from any state machine.
  function automatic void build_line(input logic [31:0] pat);
    int n;
    exp_line.delete();
    exp_line.push_back(8'h53);
    exp_line.push_back(8'h3A);
    for (int k = 0; k < STEPS; k++) begin
      n = int'((pat >> (4*k)) & 32'hF);
`ifdef SEQ_DUMP_SEP_EN
      if (k > 0) exp_line.push_back(8'h20);
`endif
      exp_line.push_back(n < 10 ? 8'(48 + n) : 8'(65 + n - 10));
    end
    exp_line.push_back(8'h0D);
    exp_line.push_back(8'h0A);
  endfunction

  // Compare process + UART ready model, every falling edge.
  task automatic monitor_loop();
    logic [7:0] prev_txdata = 8'h00;
    logic prev_rst = 1, prev_ready = 1, prev_done = 0, prev_txclk = 0;
    int low = 0, last_tx = 0, k;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        chk("reset_hold", {txdata, 1'b0, txclk, busy, done}, 32'h0);
      end else begin
        if (!txclk && !prev_rst) chk("txdata_stable", txdata, prev_txdata);
        if (txclk) begin
          k = ntx_total - base_tx;
          chk("txclk_single", prev_txclk, 0);
          chk("txclk_needs_ready", prev_ready, 1);
          if (k < exp_line.size()) chk($sformatf("byte%0d", k), txdata, exp_line[k]);
          else chk("extra_txclk", k, exp_line.size() - 1);
          if (never_drop && k > 0) chk("timeout_gap_ok", (cyc - last_tx >= BUSY_WAIT) ? 1 : 0, 1);
          last_tx = cyc;
          rx_all.push_back(txdata);
          ntx_total++;
        end
        if (done) begin
          dcount++;
          chk("done_single", prev_done, 0);
          chk("busy_low_at_done", busy, 0);
        end
      end
      prev_txclk = txclk; prev_txdata = txdata; prev_rst = rst; prev_done = done;
      prev_ready = txready;
      if (rst || never_drop) begin
        low = 0; txready = 1;
      end else if (txclk) begin
        low = (ntx_total - base_tx == stall_k) ? 52 : 2;
        txready = 0;
      end else if (low > 0) begin
        low--;
        if (low == 0) txready = 1;
      end
    end
  endtask

  task automatic do_line(input logic [31:0] pat, input bit change_pat, input bit mid_start);
    int base_done;
    bit got = 0, did = 0;
    build_line(pat);
    seq_flat = pat;
    base_tx = ntx_total;
    base_done = dcount;
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
    chk("lat_busy", busy, 1);
    chk("lat_txclk0", txclk, 0);
    if (change_pat) seq_flat = '1;
    @(negedge clk);
    chk("lat_txclk1", txclk, 1);
    chk("lat_first_S", txdata, 8'h53);
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      start = 0;
      if (done) begin got = 1; break; end
      if (mid_start && !did && ntx_total - base_tx >= 5) begin start = 1; did = 1; end
    end
    start = 0;
    chk("done_seen", got, 1);
    chk("busy_after", busy, 0);
    repeat (3) @(negedge clk);
    chk("line_len", ntx_total - base_tx, exp_line.size());
    chk("done_count", dcount - base_done, 1);
  endtask

  task automatic chk_lit(input string name);
    for (int i = 0; i < lit.size(); i++)
      chk($sformatf("%s[%0d]", name, i), (base_tx + i < rx_all.size()) ? rx_all[base_tx + i] : 8'hXX, lit[i]);
  endtask

  initial begin
    logic [7:0] digs [$];
    bit hit;
    fork monitor_loop(); join_none
    #1;
    chk("rst_state", {txdata, 1'b0, txclk, busy, done}, 32'h0);
    repeat (2) @(negedge clk);
    rst = 0;
    repeat (2) @(negedge clk);

    // 1: basic line, checked against literal bytes
    do_line(32'h87654321, 0, 0);
`ifdef SEQ_DUMP_SEP_EN
    lit = '{8'h53,8'h3A,8'h31,8'h20,8'h32,8'h20,8'h33,8'h20,8'h34,8'h20,8'h35,8'h20,
            8'h36,8'h20,8'h37,8'h20,8'h38,8'h0D,8'h0A};
`else
    lit = '{8'h53,8'h3A,8'h31,8'h32,8'h33,8'h34,8'h35,8'h36,8'h37,8'h38,8'h0D,8'h0A};
`endif
    chk_lit("t1_lit");

    // 2: A-F and zero digits
    do_line(32'h000090AF, 0, 0);
    digs.delete();
    for (int i = base_tx + 2; i < ntx_total - 2; i++)
      if (rx_all[i] != 8'h20) digs.push_back(rx_all[i]);
    lit = '{8'h46,8'h41,8'h30,8'h39,8'h30,8'h30,8'h30,8'h30};
    for (int i = 0; i < 8; i++) chk($sformatf("t2_digit%0d", i), (i < digs.size()) ? digs[i] : 8'hXX, lit[i]);

    // 3: snapshot isolation and ignored mid-line start
    do_line(32'h13579BDF, 1, 1);

    // 4a: long ready stall before byte 3
    stall_k = 2;
    do_line(32'hCAFE0123, 0, 0);
    stall_k = -1;

    // 4b: UART never drops ready, each byte advances on the wait timeout
    never_drop = 1;
    do_line(32'h87654321, 0, 0);
    never_drop = 0;
    repeat (4) @(negedge clk);

    // 5: reset after the 4th byte aborts; next line restarts from 'S'
    build_line(32'h2468ACE0);
    seq_flat = 32'h2468ACE0;
    base_tx = ntx_total;
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
    hit = 0;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      if (ntx_total - base_tx >= 4) begin hit = 1; break; end
    end
    chk("t5_reached_4", hit, 1);
    #1 rst = 1;
    #1;
    chk("t5_rst_txclk", txclk, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_txdata", txdata, 8'h00);
    repeat (3) @(negedge clk);
    rst = 0;
    repeat (3) @(negedge clk);
    chk("t5_no_tx_after_abort", ntx_total - base_tx, 4);
    do_line(32'h2468ACE0, 0, 0);
    lit = '{8'h53, 8'h3A};
    chk_lit("t5_restart");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
